// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential 27-bit floating-point multiplier.
// Format: [26] sign, [25:18] exponent (bias 127), [17:0] fraction with hidden 1.
// A shift-add core needs 19 cycles for the mantissa product, plus one normalisation cycle.
// Exponent 0 is treated as zero. Overflow saturates. Underflow flushes to zero.
// Rounding is by truncation.
module fp_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [26:0] first,
    input  logic [26:0] second,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [26:0] out,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        NORM,
        DONE
    } state_t;

    state_t             state;
    logic [37:0]        mcand;
    logic [18:0]        mplier;
    logic [37:0]        prod;
    logic [4:0]         cnt;
    logic signed [9:0]  exp_r;
    logic               sign_r;

    logic signed [9:0]  exp_n;
    logic [17:0]        frac_n;
    logic [26:0]        norm_res;
    logic               zero_op;

    // Operands are taken only in IDLE and only while reset is released.
    always_comb begin
        in_ready = rst && (state == IDLE);
    end

    // An exponent field of zero marks that operand as zero.
    always_comb begin
        zero_op = (first[25:18] == 8'd0) || (second[25:18] == 8'd0);
    end

    // Normalise the product, truncate the fraction, then saturate or flush the exponent.
    always_comb begin
        exp_n  = exp_r;
        frac_n = prod[35:18];
        if (prod[37]) begin
            exp_n  = exp_r + 10'sd1;
            frac_n = prod[36:19];
        end
        if (exp_n >= 10'sd255) begin
            norm_res = {sign_r, 8'hFE, 18'h3FFFF};
        end else if (exp_n <= 10'sd0) begin
            norm_res = {sign_r, 26'd0};
        end else begin
            norm_res = {sign_r, exp_n[7:0], frac_n};
        end
    end

    // Control FSM with the shift-add datapath and the registered result.
    // A zero operand enters DONE with out_valid still low. DONE raises it one
    // cycle later, which gives that path its one-cycle latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            cnt       <= '0;
            exp_r     <= '0;
            sign_r    <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= first[26] ^ second[26];
                        if (zero_op) begin
                            out   <= {first[26] ^ second[26], 26'd0};
                            state <= DONE;
                        end else begin
                            mcand  <= {19'd0, 1'b1, first[17:0]};
                            mplier <= {1'b1, second[17:0]};
                            prod   <= '0;
                            cnt    <= '0;
                            exp_r  <= $signed({2'b00, first[25:18]})
                                    + $signed({2'b00, second[25:18]})
                                    - 10'sd127;
                            state  <= MULT;
                        end
                    end
                end
                MULT: begin
                    if (mplier[0]) begin
                        prod <= prod + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd18) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    out       <= norm_res;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
